// File: rtl/gcn_ctrl_fsm.sv
// Control FSM for one GCN layer: sequences the feature x weight product
// pass, then the adjacency pass, then a one-cycle flush for the delayed
// output write, and finally pulses done. Counters live downstream; this
// block only enables them and watches their values for terminal count.
module gcn_ctrl_fsm #(
    parameter int FEATURE_ROWS = 6,
    parameter int WEIGHT_COLS  = 3,
    parameter int FM_WM_CNT_W  = $clog2(WEIGHT_COLS),
    parameter int ADJ_CNT_W    = $clog2(FEATURE_ROWS)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   mem_ready,
    input  logic [FM_WM_CNT_W-1:0] fm_wm_count,
    input  logic [ADJ_CNT_W-1:0]   adj_count,
    output logic                   enable_fm_wm_counter,
    output logic                   enable_adj_counter,
    output logic                   fm_wm_write_en,
    output logic                   output_write_en,
    output logic                   busy,
    output logic                   done,
    output logic                   count_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FM_WM = 3'd1,
        ADJ   = 3'd2,
        FLUSH = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic [FM_WM_CNT_W-1:0] FM_WM_LAST = FM_WM_CNT_W'(WEIGHT_COLS - 1);
    localparam logic [ADJ_CNT_W-1:0]   ADJ_LAST   = ADJ_CNT_W'(FEATURE_ROWS - 1);

    state_t state;
    logic   fm_wm_over;
    logic   adj_over;

    // Enables follow state and mem_ready directly so a stall gates them in the same cycle
    always_comb begin
        enable_fm_wm_counter = (state == FM_WM) && mem_ready;
        fm_wm_write_en       = (state == FM_WM) && mem_ready;
        enable_adj_counter   = (state == ADJ) && mem_ready;
        busy                 = (state != IDLE);
        done                 = (state == DONE);
        fm_wm_over           = (state == FM_WM) && (fm_wm_count > FM_WM_LAST);
        adj_over             = (state == ADJ) && (adj_count > ADJ_LAST);
    end

    // State register, delayed output write (read_row lags the adj counter by one cycle) and sticky range error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            output_write_en <= 1'b0;
            count_err       <= 1'b0;
        end else begin
            output_write_en <= enable_adj_counter;
            if (fm_wm_over || adj_over) begin
                count_err <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= FM_WM;
                        count_err <= 1'b0;
                    end
                end
                FM_WM: begin
                    if (mem_ready && (fm_wm_count == FM_WM_LAST)) begin
                        state <= ADJ;
                    end
                end
                ADJ: begin
                    if (mem_ready && (adj_count == ADJ_LAST)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: state <= DONE;
                DONE:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gcn_ctrl_fsm.sv
// Bench for gcn_ctrl_fsm with a behavioural model of the downstream
// counters. Cycle k is the clock period that ends at edge k; inputs held
// during cycle k are sampled at edge k, so a start in cycle 0 gives
// FM_WM from cycle 1 and done on cycle 11.
module tb_gcn_ctrl_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       mem_ready;
    logic [1:0] fm_wm_count;
    logic [2:0] adj_count;
    logic       enable_fm_wm_counter;
    logic       enable_adj_counter;
    logic       fm_wm_write_en;
    logic       output_write_en;
    logic       busy;
    logic       done;
    logic       count_err;

    logic       adj_force;
    logic [1:0] fm_m;
    logic [2:0] adj_m;

    int total = 0;
    int bad   = 0;

    logic [63:0] o_fm, o_wr, o_adj, o_owe, o_busy, o_done, o_err;
    logic [63:0] s_in, m_in, r_in, f_in;

    typedef struct {
        logic       st;
        logic       mr;
        logic [6:0] exp;   // {fm_en, fm_wr, adj_en, out_wr, busy, done, err}
    } vec_t;

    vec_t tbl[13];

    gcn_ctrl_fsm dut (
        .clk                  (clk),
        .reset                (reset),
        .start                (start),
        .mem_ready            (mem_ready),
        .fm_wm_count          (fm_wm_count),
        .adj_count            (adj_count),
        .enable_fm_wm_counter (enable_fm_wm_counter),
        .enable_adj_counter   (enable_adj_counter),
        .fm_wm_write_en       (fm_wm_write_en),
        .output_write_en      (output_write_en),
        .busy                 (busy),
        .done                 (done),
        .count_err            (count_err)
    );

    always #5 clk = ~clk;

    // Downstream counters: wrap at their last index, cleared by reset
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            fm_m  <= 2'd0;
            adj_m <= 3'd0;
        end else begin
            if (enable_fm_wm_counter) fm_m  <= (fm_m == 2'd2) ? 2'd0 : fm_m + 2'd1;
            if (enable_adj_counter)   adj_m <= (adj_m == 3'd5) ? 3'd0 : adj_m + 3'd1;
        end
    end

    assign fm_wm_count = fm_m;
    assign adj_count   = adj_force ? 3'd7 : adj_m;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, req);
        end
    endtask

    function automatic logic [6:0] pk(input int i);
        return {o_fm[i], o_wr[i], o_adj[i], o_owe[i], o_busy[i], o_done[i], o_err[i]};
    endfunction

    function automatic int first_one(input logic [63:0] v);
        for (int i = 0; i < 64; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Drive one cycle's inputs, record outputs for cycle i, then cross the edge
    task automatic cyc(input logic s, input logic m, input logic r, input logic f, input int i);
        start     = s;
        mem_ready = m;
        reset     = r;
        adj_force = f;
        #1;
        o_fm[i]   = enable_fm_wm_counter;
        o_wr[i]   = fm_wm_write_en;
        o_adj[i]  = enable_adj_counter;
        o_owe[i]  = output_write_en;
        o_busy[i] = busy;
        o_done[i] = done;
        o_err[i]  = count_err;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_io();
        s_in = '0; m_in = '1; r_in = '0; f_in = '0;
        o_fm = '0; o_wr = '0; o_adj = '0; o_owe = '0;
        o_busy = '0; o_done = '0; o_err = '0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc(s_in[i], m_in[i], r_in[i], f_in[i], i);
        start = 1'b0; mem_ready = 1'b1; reset = 1'b0; adj_force = 1'b0;
    endtask

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 7'b0000000};
        tbl[1]  = '{1'b0, 1'b1, 7'b1100100};
        tbl[2]  = '{1'b0, 1'b1, 7'b1100100};
        tbl[3]  = '{1'b0, 1'b1, 7'b1100100};
        tbl[4]  = '{1'b0, 1'b1, 7'b0010100};
        tbl[5]  = '{1'b0, 1'b1, 7'b0011100};
        tbl[6]  = '{1'b0, 1'b1, 7'b0011100};
        tbl[7]  = '{1'b0, 1'b1, 7'b0011100};
        tbl[8]  = '{1'b0, 1'b1, 7'b0011100};
        tbl[9]  = '{1'b0, 1'b1, 7'b0011100};
        tbl[10] = '{1'b0, 1'b1, 7'b0001100};
        tbl[11] = '{1'b0, 1'b1, 7'b0000110};
        tbl[12] = '{1'b0, 1'b1, 7'b0000000};

        reset = 1'b1; start = 1'b1; mem_ready = 1'b1; adj_force = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs",
            {57'd0, enable_fm_wm_counter, fm_wm_write_en, enable_adj_counter,
             output_write_en, busy, done, count_err}, 64'd0);
        start = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Nominal run, compared cycle by cycle against the table
        clear_io();
        for (int i = 0; i < 13; i++) begin
            cyc(tbl[i].st, tbl[i].mr, 1'b0, 1'b0, i);
            chk($sformatf("nominal_c%0d", i), {57'd0, pk(i)}, {57'd0, tbl[i].exp});
        end

        // Two-cycle stalls in FM_WM (cycles 2-3) and ADJ (cycles 7-8)
        clear_io();
        s_in[0] = 1'b1;
        m_in[2] = 1'b0; m_in[3] = 1'b0; m_in[7] = 1'b0; m_in[8] = 1'b0;
        run(18);
        chk("stall_enables_off", {o_fm[2], o_fm[3], o_wr[2], o_wr[3], o_adj[7], o_adj[8]}, 0);
        chk("stall_owe_after", {o_owe[8], o_owe[9]}, 0);
        chk("stall_fm_writes", $countones(o_wr), 3);
        chk("stall_out_writes", $countones(o_owe), 6);
        chk("stall_done_cycle", first_one(o_done), 15);
        chk("stall_done_count", $countones(o_done), 1);

        // Stall exactly on the terminal count of each phase
        clear_io();
        s_in[0] = 1'b1;
        m_in[3] = 1'b0; m_in[10] = 1'b0;
        run(16);
        chk("term_fm_held", {o_fm[3], o_fm[4], o_adj[4]}, 3'b010);
        chk("term_adj_held", {o_adj[10], o_adj[11], o_busy[12], o_adj[12]}, 4'b0110);
        chk("term_fm_writes", $countones(o_wr), 3);
        chk("term_out_writes", $countones(o_owe), 6);
        chk("term_done_cycle", first_one(o_done), 13);

        // Start pulse while busy is ignored
        clear_io();
        s_in[0] = 1'b1; s_in[5] = 1'b1;
        run(16);
        chk("busy_start_busy", o_busy[15:0], 16'h0FFE);
        chk("busy_start_done", o_done[15:0], 16'h0800);

        // Start held high: back-to-back runs
        clear_io();
        for (int i = 0; i < 24; i++) s_in[i] = 1'b1;
        run(26);
        chk("b2b_done", o_done[25:0], (26'd1 << 11) | (26'd1 << 23));
        chk("b2b_idle_c12", {o_busy[12], o_fm[12], o_fm[13]}, 3'b001);
        chk("b2b_busy_c24", o_busy[24], 1'b0);

        // Asynchronous reset mid-ADJ, fresh start afterwards
        clear_io();
        s_in[0] = 1'b1; r_in[6] = 1'b1; r_in[7] = 1'b1; s_in[10] = 1'b1;
        run(23);
        chk("rst_c5_active", {o_adj[5], o_busy[5]}, 2'b11);
        chk("rst_outputs_c6", {57'd0, pk(6)}, 64'd0);
        chk("rst_idle_c6_10", o_busy[10:6], 5'd0);
        chk("rst_done_cycle", first_one(o_done), 21);
        chk("rst_done_count", $countones(o_done), 1);

        // Out-of-range adjacency count for one ADJ cycle
        clear_io();
        s_in[0] = 1'b1; f_in[5] = 1'b1; s_in[12] = 1'b1;
        run(26);
        chk("err_not_yet", o_err[5:0], 6'd0);
        chk("err_sticky", o_err[12:6], 7'h7F);
        chk("err_cleared", o_err[25:13], 13'd0);
        chk("err_done", o_done[25:0], (26'd1 << 11) | (26'd1 << 23));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/gcn_ctrl_fsm.md
GCN_CTRL_FSM -- requirements
Module: gcn_ctrl_fsm

Interface
REQ-001 Parameter FEATURE_ROWS, default 6: number of adjacency/output rows to process.
REQ-002 Parameter WEIGHT_COLS, default 3: number of weight columns (feature x weight products) to process.
REQ-003 Parameter FM_WM_CNT_W, default $clog2(WEIGHT_COLS): width of fm_wm_count.
REQ-004 Parameter ADJ_CNT_W, default $clog2(FEATURE_ROWS): width of adj_count.
REQ-005 The block SHALL have one clock, clk, with all state updated on its rising edge.
REQ-006 The block SHALL have reset, input, 1 bit, asynchronous and active-high.
REQ-007 start  input  1  request to run one full layer computation; level-sampled in IDLE only.
REQ-008 mem_ready  input  1  downstream memories ready; low stalls counter advance.
REQ-009 fm_wm_count  input  FM_WM_CNT_W  current value of the downstream feature x weight counter.
REQ-010 adj_count  input  ADJ_CNT_W  current value of the downstream adjacency counter.
REQ-011 enable_fm_wm_counter  output  1  advance the feature x weight counter.
REQ-012 enable_adj_counter  output  1  advance the adjacency counter.
REQ-013 fm_wm_write_en  output  1  write the current feature x weight product column.
REQ-014 output_write_en  output  1  write the output row at the counter block's read_row.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  single-cycle completion pulse.
REQ-017 count_err  output  1  sticky; a counter value is out of range.

Function
REQ-018 The FSM SHALL have the states IDLE, FM_WM, ADJ, FLUSH and DONE, held in a register.
- IDLE -> FM_WM when start=1.
- FM_WM -> ADJ when mem_ready=1 and fm_wm_count==WEIGHT_COLS-1.
- ADJ -> FLUSH when mem_ready=1 and adj_count==FEATURE_ROWS-1.
- FLUSH -> DONE unconditionally.
- DONE -> IDLE unconditionally.
REQ-019 enable_fm_wm_counter and fm_wm_write_en SHALL both be combinational, equal to (state==FM_WM && mem_ready).
REQ-020 enable_adj_counter SHALL be combinational, equal to (state==ADJ && mem_ready).
REQ-021 output_write_en SHALL be a register loaded each cycle with enable_adj_counter, compensating the one-cycle read_row lag.
- As a result, output_write_en is high during FLUSH for the last row.
REQ-022 While mem_ready=0 in FM_WM or ADJ:
- the state SHALL hold;
- all enables SHALL be 0;
- output_write_en SHALL be 0 on the following cycle.
REQ-023 done SHALL be 1 only in DONE.
REQ-024 busy SHALL be combinational, equal to (state!=IDLE).
REQ-025 start SHALL be ignored while busy=1; no restart and no queuing.
REQ-026 If start is still high in DONE, the FSM SHALL return to IDLE and then begin a new run on the following cycle.
REQ-027 With mem_ready held at 1 and start sampled at edge 0:
- FM_WM occupies cycles 1..WEIGHT_COLS;
- ADJ occupies the next FEATURE_ROWS cycles;
- FLUSH follows for 1 cycle;
- done follows 1 cycle later (cycle 11 for the defaults).
REQ-028 count_err SHALL set on a clock edge if either condition holds:
- state==FM_WM and fm_wm_count>WEIGHT_COLS-1;
- state==ADJ and adj_count>FEATURE_ROWS-1.
REQ-029 count_err SHALL stay set until reset or until the next accepted start; the FSM SHALL continue normally while it is set.
REQ-030 If mem_ready drops on the terminal-count cycle, the transition SHALL wait until mem_ready returns with the count still terminal.

Reset
REQ-031 While reset=1, the block SHALL hold:
- state=IDLE;
- output_write_en=0 and count_err=0;
- all combinational outputs at 0.
REQ-032 Reset asserted in any state, including mid-ADJ, SHALL abort the run immediately with no done pulse; a new run requires a fresh start.

Verification
REQ-033 Nominal run: FEATURE_ROWS=6, WEIGHT_COLS=3, mem_ready=1, bench counter model, start pulse at edge 0 -> required response:
- fm_wm enables high on cycles 1-3;
- enable_adj_counter high on cycles 4-9;
- output_write_en high on cycles 5-10;
- done high on cycle 11 only;
- busy high on cycles 1-11.
REQ-034 Stall: mem_ready=0 for 2 cycles at cycle 2 (FM_WM) and 2 cycles at cycle 7 (ADJ) -> required response:
- enables are 0 during each stall;
- no duplicate or missing write pulses (exactly 3 fm_wm_write_en and 6 output_write_en);
- done arrives 4 cycles late, on cycle 15.
REQ-035 Start while busy: pulse start at cycle 5 -> no effect on the sequence; single done on cycle 11.
REQ-036 Back-to-back: start held high continuously -> done on cycle 11, IDLE on cycle 12, second run's FM_WM from cycle 13, second done on cycle 23.
REQ-037 Reset mid-run: assert reset asynchronously during cycle 6 (ADJ), release at cycle 8 -> required response:
- all outputs drop to 0 immediately;
- state stays IDLE with no done pulse;
- a fresh start at cycle 10 gives done on cycle 21.
REQ-038 Count error: force adj_count=7 during ADJ -> count_err=1 from the next edge, held through done, cleared by the next start.
